// File: rtl/alu_op_sequencer_if.sv
// Command handshake, shared-bus view and ALU control/operand signals of the ALU op sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_op is sampled only then.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             done;
    logic             src_oe;
    logic [WIDTH-1:0] bus;
    logic             alu_oe;
    logic             alu_sub;
    logic             cf_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             z_flag;
    logic             c_flag;
    logic [2:0]       dbg_state;

    modport master (
        output cmd_valid, cmd_op, bus, cf_in,
        input  cmd_ready, done, src_oe, alu_oe, alu_sub, a, b, z_flag, c_flag, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, bus, cf_in,
        output cmd_ready, done, src_oe, alu_oe, alu_sub, a, b, z_flag, c_flag, dbg_state
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control/operand end of an 8-bit SAP-style ALU: fetches operands off the shared bus,
// enables the ALU and captures result and flags back into A.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus_if
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             src_oe_q, src_oe_d;
    logic             alu_oe_q, alu_oe_d;
    logic             alu_sub_q, alu_sub_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        c_d     = c_q;
        sub_d   = sub_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.cmd_valid) begin
                    case (bus_if.cmd_op)
                        2'b00: state_d = S_FETCH_A;
                        2'b01: begin
                            state_d = S_FETCH_B;
                            sub_d   = 1'b0;
                        end
                        2'b10: begin
                            state_d = S_FETCH_B;
                            sub_d   = 1'b1;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_FETCH_A: begin
                a_d     = bus_if.bus;
                state_d = S_DONE;
            end
            S_FETCH_B: begin
                b_d     = bus_if.bus;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // The ALU result is on the bus this cycle; capture it with its flags.
                a_d     = bus_if.bus;
                z_d     = (bus_if.bus == '0);
                c_d     = bus_if.cf_in;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they depend on state only.
    always_comb begin
        src_oe_d    = (state_d == S_FETCH_A) || (state_d == S_FETCH_B);
        alu_oe_d    = (state_d == S_EXEC);
        alu_sub_d   = (state_d == S_EXEC) && sub_d;
        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            sub_q       <= 1'b0;
            src_oe_q    <= 1'b0;
            alu_oe_q    <= 1'b0;
            alu_sub_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            z_q         <= z_d;
            c_q         <= c_d;
            sub_q       <= sub_d;
            src_oe_q    <= src_oe_d;
            alu_oe_q    <= alu_oe_d;
            alu_sub_q   <= alu_sub_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
        end
    end

    assign bus_if.cmd_ready = cmd_ready_q;
    assign bus_if.done      = done_q;
    assign bus_if.src_oe    = src_oe_q;
    assign bus_if.alu_oe    = alu_oe_q;
    assign bus_if.alu_sub   = alu_sub_q;
    assign bus_if.a         = a_q;
    assign bus_if.b         = b_q;
    assign bus_if.z_flag    = z_q;
    assign bus_if.c_flag    = c_q;
    assign bus_if.dbg_state = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: plays memory source and ALU on the bus, and checks
// register, flag and handshake behaviour against a transaction-level model.
module tb_alu_op_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] src_val = '0;
    logic [W:0]   alu_res;

    alu_op_sequencer_if #(.WIDTH(W)) dut_if ();

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (dut_if)
    );

    // ALU and source device sharing the bus.
    assign alu_res = dut_if.alu_sub ? ({1'b0, dut_if.a} - {1'b0, dut_if.b})
                                    : ({1'b0, dut_if.a} + {1'b0, dut_if.b});
    assign dut_if.bus   = dut_if.alu_oe ? alu_res[W-1:0] : src_val;
    assign dut_if.cf_in = alu_res[W];

    // Reference model of the architectural state.
    int m_a = 0;
    int m_b = 0;
    int m_z = 0;
    int m_c = 0;

    task automatic model_apply(input int op, input int val);
        int r;
        case (op)
            0: m_a = val;
            1: begin
                m_b = val;
                r   = m_a + val;
                m_c = (r >= (1 << W)) ? 1 : 0;
                m_a = r % (1 << W);
                m_z = (m_a == 0) ? 1 : 0;
            end
            2: begin
                m_b = val;
                r   = m_a - val;
                m_c = (r < 0) ? 1 : 0;
                m_a = (r + (1 << W)) % (1 << W);
                m_z = (m_a == 0) ? 1 : 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_a = 0;
        m_b = 0;
        m_z = 0;
        m_c = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_a"}, 32'(dut_if.a), 32'(m_a));
        chk({tag, "_b"}, 32'(dut_if.b), 32'(m_b));
        chk({tag, "_z"}, 32'(dut_if.z_flag), 32'(m_z));
        chk({tag, "_c"}, 32'(dut_if.c_flag), 32'(m_c));
    endtask

    // Bus exclusivity and single-cycle done, every cycle once the clock has run.
    logic started = 1'b0;
    logic prev_done = 1'b0;
    always @(posedge clk) started <= 1'b1;
    always @(negedge clk) begin
        if (started) begin
            checks++;
            assert ((dut_if.src_oe & dut_if.alu_oe) === 1'b0) else begin
                failures++;
                $error("FAIL bus_contention observed=1 expected=0");
            end
            checks++;
            assert ((dut_if.done === 1'b1 && prev_done) === 1'b0) else begin
                failures++;
                $error("FAIL done_pulse observed=2cycles expected=1cycle");
            end
        end
        prev_done = (dut_if.done === 1'b1);
    end

    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 10 && dut_if.cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_before_accept", 32'(dut_if.cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] val);
        int lat = 0;
        int n_src = 0;
        int n_alu = 0;
        int n_sub = 0;
        int n_sub_bad = 0;
        wait_ready();
        dut_if.cmd_valid = 1'b1;
        dut_if.cmd_op    = op;
        src_val          = val;
        @(negedge clk);
        dut_if.cmd_valid = 1'b0;
        model_apply(int'(op), int'(val));
        for (int i = 1; i <= 8; i++) begin
            if (dut_if.src_oe === 1'b1) n_src++;
            if (dut_if.alu_oe === 1'b1) n_alu++;
            if (dut_if.alu_sub === 1'b1) n_sub++;
            if (dut_if.alu_sub === 1'b1 && dut_if.alu_oe !== 1'b1) n_sub_bad++;
            if (dut_if.done === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("latency", lat, (op == 2'd3) ? 1 : (op == 2'd0) ? 2 : 3);
        chk("src_oe_cycles", n_src, (op == 2'd3) ? 0 : 1);
        chk("alu_oe_cycles", n_alu, (op == 2'd1 || op == 2'd2) ? 1 : 0);
        chk("alu_sub_cycles", n_sub, (op == 2'd2) ? 1 : 0);
        chk("alu_sub_outside_exec", n_sub_bad, 0);
        chk("done_ready_low", 32'(dut_if.cmd_ready), 32'd0);
        chk_regs("regs");
    endtask

    task automatic reset_mid(input logic [1:0] op, input logic [W-1:0] val, input int k);
        wait_ready();
        dut_if.cmd_valid = 1'b1;
        dut_if.cmd_op    = op;
        src_val          = val;
        @(negedge clk);
        dut_if.cmd_valid = 1'b0;
        repeat (k) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        chk_regs("rst_mid");
        chk("rst_mid_ready", 32'(dut_if.cmd_ready), 32'd1);
        chk("rst_mid_src_oe", 32'(dut_if.src_oe), 32'd0);
        chk("rst_mid_alu_oe", 32'(dut_if.alu_oe), 32'd0);
        chk("rst_mid_done", 32'(dut_if.done), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last;
        int n_acc;
        logic [1:0] op;
        logic [W-1:0] val;

        dut_if.cmd_valid = 1'b0;
        dut_if.cmd_op    = 2'd0;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        chk_regs("reset");
        chk("reset_ready", 32'(dut_if.cmd_ready), 32'd1);
        chk("reset_src_oe", 32'(dut_if.src_oe), 32'd0);
        chk("reset_alu_oe", 32'(dut_if.alu_oe), 32'd0);
        chk("reset_done", 32'(dut_if.done), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases, including overflow, borrow and zero results.
        do_cmd(2'd0, 8'h05);
        do_cmd(2'd1, 8'h03);
        chk("add_a", 32'(dut_if.a), 32'h08);
        do_cmd(2'd0, 8'h01);
        do_cmd(2'd1, 8'hFF);
        chk("ovf_flags", {30'd0, dut_if.z_flag, dut_if.c_flag}, 32'b11);
        do_cmd(2'd0, 8'h03);
        do_cmd(2'd2, 8'h05);
        chk("borrow_a", 32'(dut_if.a), 32'hFE);
        do_cmd(2'd0, 8'h05);
        do_cmd(2'd2, 8'h05);
        chk("sub_zero_flags", {30'd0, dut_if.z_flag, dut_if.c_flag}, 32'b10);
        do_cmd(2'd3, 8'h77);

        // Reset while the ADD is in its execute cycle.
        do_cmd(2'd0, 8'h09);
        reset_mid(2'd1, 8'h07, 1);

        // cmd_valid held high with ADD: one accept every 4 cycles.
        wait_ready();
        dut_if.cmd_valid = 1'b1;
        dut_if.cmd_op    = 2'd1;
        src_val          = 8'h11;
        last  = -1;
        n_acc = 0;
        for (int i = 0; i < 17; i++) begin
            if (dut_if.cmd_ready === 1'b1) begin
                if (last >= 0) chk("accept_spacing", i - last, 4);
                last = i;
                n_acc++;
                model_apply(1, 8'h11);
            end
            @(negedge clk);
        end
        dut_if.cmd_valid = 1'b0;
        chk("accept_count", n_acc, 5);
        for (int i = 0; i < 8 && dut_if.done !== 1'b1; i++) @(negedge clk);
        chk_regs("hold_add");

        // Random command stream with occasional reset pulses.
        for (int n = 0; n < 60; n++) begin
            op  = 2'($urandom_range(0, 3));
            val = ($urandom_range(0, 3) == 0) ? W'(m_a) : W'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) reset_mid(op, val, $urandom_range(0, 3));
            else do_cmd(op, val);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
